// File: rtl/sync_sram_ctrl_if.sv
// Request/response, chip-select and clear-sweep signals of the synchronous SRAM controller.
// The master modport is the requester side. The slave modport is the controller side.
interface sync_sram_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic                cs1_n;
  logic                cs2;
  logic                req_valid;
  logic                req_ready;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] be;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rdata;
  logic                clr;
  logic                clr_busy;
  logic                clr_done;

  modport master (
    output cs1_n, cs2, req_valid, we, addr, wdata, be, clr,
    input  req_ready, rsp_valid, rdata, clr_busy, clr_done
  );

  modport slave (
    input  cs1_n, cs2, req_valid, we, addr, wdata, be, clr,
    output req_ready, rsp_valid, rdata, clr_busy, clr_done
  );
endinterface

// File: rtl/sync_sram_ctrl.sv
// Single-port synchronous SRAM controller with byte-enabled writes and a fixed read-latency pipeline.
// It also provides a full-array zero sweep. The array contents survive reset.
module sync_sram_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  sync_sram_ctrl_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, TURN, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_done_q, clr_done_d;
  logic [RD_LAT:0]     rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   rd_data_q [RD_LAT+1];
  logic [DATA_W-1:0]   rd_data_d [RD_LAT+1];

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                chip_en;
  logic                accept;
  logic                wr_accept;
  logic                rd_accept;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_wbe;

  assign chip_en       = !bus.cs1_n && bus.cs2;
  assign bus.req_ready = (state_q == IDLE) && chip_en && !bus.clr;
  assign accept        = bus.req_valid && bus.req_ready;
  assign wr_accept     = accept && bus.we;
  assign rd_accept     = accept && !bus.we;

  assign bus.clr_busy  = (state_q == CLEAR);
  assign bus.clr_done  = clr_done_q;
  assign bus.rsp_valid = rd_vld_q[RD_LAT];
  assign bus.rdata     = rd_data_q[RD_LAT];

  // A clear request takes priority over a request in IDLE, and chip select does not gate it.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (wr_accept) begin
          state_d = TURN;
        end
      end
      TURN: state_d = IDLE;
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.addr;
    mem_wdata = bus.wdata;
    mem_wbe   = bus.be;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      mem_wbe   = '1;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  // Each data stage loads only when its upstream stage is valid, so rdata holds between responses.
  always_comb begin
    rd_vld_d  = {rd_vld_q[RD_LAT-1:0], rd_accept};
    rd_data_d = rd_data_q;
    if (rd_accept) rd_data_d[0] = mem[bus.addr];
    for (int i = 1; i <= RD_LAT; i++) begin
      if (rd_vld_q[i-1]) rd_data_d[i] = rd_data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
      rd_vld_q   <= '0;
      for (int i = 0; i <= RD_LAT; i++) rd_data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wbe[i]) mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
  end
endmodule

// File: doc/sync_sram_ctrl.md
SYNC_SRAM_CTRL -- requirements
Module: sync_sram_ctrl

Interface
REQ-001 Parameter: DATA_W, default 16, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter: ADDR_W, default 13, address width; DEPTH SHALL be 2**ADDR_W words.
REQ-003 Parameter: RD_LAT, default 2, read latency in cycles; legal range 1..4.
REQ-004 Port: clk  in  1  single clock; all state SHALL change on its rising edge except under reset.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: cs1_n  in  1  active-low chip select.
REQ-007 Port: cs2  in  1  active-high chip select; chip SHALL be enabled only when cs1_n=0 and cs2=1.
REQ-008 Port: req_valid  in  1  request present.
REQ-009 Port: req_ready  out  1  request can be accepted this cycle.
REQ-010 Port: we  in  1  1=write request, 0=read request.
REQ-011 Port: addr  in  ADDR_W  word address.
REQ-012 Port: wdata  in  DATA_W  write data.
REQ-013 Port: be  in  DATA_W/8  byte enables; bit i controls byte i (LSB byte = bit 0).
REQ-014 Port: rsp_valid  out  1  single-cycle pulse qualifying rdata.
REQ-015 Port: rdata  out  DATA_W  read data; SHALL hold its last value when rsp_valid=0.
REQ-016 Port: clr  in  1  single-cycle pulse starting a full-array zero sweep.
REQ-017 Port: clr_busy  out  1  sweep in progress.
REQ-018 Port: clr_done  out  1  single-cycle pulse on completion of the sweep.

Function
REQ-019 FSM states SHALL be IDLE, TURN, CLEAR.
REQ-020 req_ready SHALL be 1 only in IDLE with the chip enabled and clr=0.
REQ-021 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-022 Accepted write: on the accepting edge, each byte with be[i]=1 SHALL be written; bytes with be[i]=0 SHALL be unchanged; FSM SHALL go to TURN.
REQ-023 TURN SHALL last exactly one cycle with req_ready=0, then return to IDLE; write throughput SHALL be one write per two cycles.
REQ-024 A write with be=0 SHALL leave memory unchanged but still enter TURN.
REQ-025 Accepted read: the array SHALL be sampled on the accepting edge; rsp_valid and rdata SHALL appear exactly RD_LAT cycles after acceptance.
REQ-026 Back-to-back reads SHALL be accepted on consecutive cycles, with one response per cycle in request order.
REQ-027 A read accepted on the cycle after TURN of a write to the same address SHALL return the newly written data.
REQ-028 A read accepted in the same cycle that the chip becomes disabled SHALL not occur: acceptance SHALL require enable in that cycle. Reads already in flight SHALL complete regardless of chip select.
REQ-029 clr=1 in IDLE SHALL take priority over a simultaneous req_valid; that request SHALL not be accepted. FSM SHALL enter CLEAR with the sweep counter at 0.
REQ-030 clr asserted in TURN SHALL be ignored. clr asserted in CLEAR SHALL be ignored. clr SHALL be honoured regardless of chip select.
REQ-031 CLEAR SHALL write 0 to address counter value each cycle for DEPTH cycles (0..DEPTH-1); clr_busy=1 throughout; req_ready=0.
REQ-032 On the edge writing address DEPTH-1, the FSM SHALL return to IDLE; clr_done SHALL pulse in the following cycle; clr_busy SHALL be 0 in that cycle.
REQ-033 Reads in flight when CLEAR starts SHALL complete with the pre-clear data.

Reset
REQ-034 rst=1 SHALL immediately force: FSM=IDLE, sweep counter=0, read pipeline valids=0, rsp_valid=0, rdata=0, clr_busy=0, clr_done=0. req_ready then follows REQ-020.
REQ-035 Memory contents SHALL be unaffected by reset; reset mid-CLEAR SHALL abort the sweep without clr_done, leaving a partially cleared array.
REQ-036 Reset deassertion SHALL be sampled synchronously; first acceptance SHALL be possible on the first edge after deassertion.

Verification (DATA_W=16, ADDR_W=4, RD_LAT=2)
REQ-037 Write addr 3 data 0xABCD be=11, then read addr 3 -> req_ready=0 one cycle after write; rsp_valid 2 cycles after read accept with rdata=0xABCD.
REQ-038 Write addr 3 data 0x1234 be=01 over 0xABCD -> later read addr 3 returns 0xAB34; write addr 3 with be=00 -> value unchanged.
REQ-039 Four consecutive reads addr 0..3 -> four consecutive rsp_valid pulses in order, first 2 cycles after the first accept.
REQ-040 Pulse clr with req_valid=1 -> request not accepted; clr_busy=1 for 16 cycles; clr_done one pulse; subsequent reads of all 16 addresses return 0x0000.
REQ-041 Toggle cs1_n=1 or cs2=0 with req_valid=1 -> req_ready=0, no writes; restore enable -> acceptance resumes.
REQ-042 Assert rst at sweep address 7 -> clr_busy, rsp_valid drop immediately; no clr_done; addresses 0..6 read 0, address 8 retains its prior value.
